uart_rx_frame: RTL
==================

# uart_rx_frame

Parametrised UART receiver with configurable data width, parity mode and stop-bit count. Adds per-frame parity/framing error detection and a valid/ready output handshake with overrun reporting. Sits between the pad-side serial input and the byte-stream consumer, clocked by the oversampling tick clock from the baud generator.

## Interface
- OVERSAMPLING, 16: clk_in cycles per bit; even, 4..64 (≥8 when majority voting is compiled in)
- DATA_BITS, 8: payload bits per frame, 5..9
- PARITY, 0: 0 none, 1 even, 2 odd
- STOP_BITS, 1: 1 or 2
- clk_in  in  1  oversampling clock (OVERSAMPLING × baud)
- nrst_in  in  1  reset, asynchronous, active-low
- rx_serial_in  in  1  asynchronous serial line, idle high
- rx_ready_in  in  1  consumer accepts the held frame
- rx_valid_out  out  1  held frame available
- rx_data_out  out  DATA_BITS  received payload, LSB received first
- parity_err_out  out  1  parity mismatch for the held frame (0 when PARITY=0)
- frame_err_out  out  1  one or more stop bits sampled low for the held frame
- overrun_err_out  out  1  one-cycle pulse: completed frame dropped

## Operation
- rx_serial_in passes through a 2-flop synchroniser; both flops reset to 1. All decisions use the synchronised value.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: synchronised line low → START with the bit counter cleared. The cycle in which IDLE sees low is t0.
- START: at t0+OVERSAMPLING/2, the line is low → DATA; high → IDLE (glitch rejected, nothing reported).
- DATA: bit k (k=0..DATA_BITS-1) is sampled at t0+OVERSAMPLING/2+(k+1)·OVERSAMPLING into shift position k. After the last bit → PARITY if PARITY≠0, else STOP.
- PARITY: sampled one bit period later. Error when the XOR of the data bits and the parity bit is 1 (even mode) or 0 (odd mode).
- STOP: STOP_BITS samples at one-bit spacing. Any low sample sets the frame error. After the last stop sample → IDLE immediately, so a start edge in the second half of the stop bit is detected.
- Output register: on completion, if rx_valid_out=0, or rx_valid_out=1 with rx_ready_in=1 in the same cycle, load data and flags and set rx_valid_out=1.
- If rx_valid_out=1 with rx_ready_in=0 at completion: discard the new frame, keep the held frame unchanged, and pulse overrun_err_out for one cycle.
- rx_valid_out clears on the cycle after rx_valid_out && rx_ready_in when no frame completes in that same cycle. Data and flags stay stable while rx_valid_out=1.
- Frames with errors are still delivered; the flags accompany the data.

## Timing
- Reset: state IDLE, counters 0. rx_valid_out, rx_data_out, parity_err_out, frame_err_out and overrun_err_out are all 0.
- Reset mid-frame aborts the frame with no output. Reception resumes at the next falling edge after reset release.
- Input edge to t0: 2–3 cycles (synchroniser).
- Last sample point S = t0+OVERSAMPLING/2+(DATA_BITS+(PARITY≠0)+STOP_BITS)·OVERSAMPLING.
- rx_valid_out rises at S+1. For 8N1 at OVERSAMPLING=16: S=t0+152, rx_valid_out at t0+153.
- overrun_err_out pulses at S+1 of the dropped frame.
- Bit counter width: $clog2(OVERSAMPLING). Bit index width covers DATA_BITS+2 without wrap.

## Configuration
- UART_RX_MAJORITY_EN defined: each sample point (start, data, parity, stop) takes 3 samples at point−1, point and point+1. The decided value is the 2-of-3 majority, taken at point+1, so all sample points and S shift by +1 cycle.
- UART_RX_MAJORITY_EN undefined: single sample at the point; timing exactly as above.

## Test plan
- 8N1, OVERSAMPLING=16, rx_ready_in=1, send 0xA5 → rx_valid_out=1 at t0+153 for one cycle with rx_data_out=0xA5 and all error flags 0.
- PARITY=1, send 0x03 with parity bit 1 → rx_data_out=0x03, parity_err_out=1. Repeat with parity bit 0 → parity_err_out=0.
- STOP_BITS=2, send 0x5A with second stop bit low → rx_data_out=0x5A, frame_err_out=1. Next frame is received normally.
- Line low for 4 ticks then high (OVERSAMPLING=16) → returns to IDLE, no rx_valid_out. A subsequent 0x3C frame is received correctly.
- rx_ready_in=0, back-to-back 0x11 then 0x22 → rx_data_out stays 0x11 and overrun_err_out pulses once at the second frame's S+1. Raising rx_ready_in then clears rx_valid_out next cycle.
- nrst_in pulsed during DATA of 0xFF → all outputs 0. Following 0x81 frame is received correctly. With UART_RX_MAJORITY_EN, a 1-tick inverted glitch at a data-bit midpoint does not change rx_data_out.

Source files
------------

// File: rtl/uart_rx_frame_if.sv
// Output side of uart_rx_frame: held frame, error flags and valid/ready handshake.
// master = receiver, slave = byte-stream consumer.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_ready_in;
  logic                 rx_valid_out;
  logic [DATA_BITS-1:0] rx_data_out;
  logic                 parity_err_out;
  logic                 frame_err_out;
  logic                 overrun_err_out;

  modport master (
    input  rx_ready_in,
    output rx_valid_out,
    output rx_data_out,
    output parity_err_out,
    output frame_err_out,
    output overrun_err_out
  );

  modport slave (
    output rx_ready_in,
    input  rx_valid_out,
    input  rx_data_out,
    input  parity_err_out,
    input  frame_err_out,
    input  overrun_err_out
  );
endinterface

// File: rtl/uart_rx_frame.sv
// Oversampled UART receiver: parity/framing checks, valid/ready output, overrun pulse.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting at every sample point.
module uart_rx_frame #(
  parameter int OVERSAMPLING = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk_in,
  input  logic            nrst_in,
  input  logic            rx_serial_in,
  uart_rx_frame_if.master rx_if
);
  localparam int CW = $clog2(OVERSAMPLING);
  localparam int IW = $clog2(DATA_BITS + 3);
  localparam logic [CW-1:0] BIT_CMP = CW'(OVERSAMPLING - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] START_CMP = CW'(OVERSAMPLING / 2);
`else
  localparam logic [CW-1:0] START_CMP = CW'(OVERSAMPLING / 2 - 1);
`endif
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_valid;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_pe;
  logic                 r_fe;
  logic                 r_ovr;

  logic w_rx;
  logic w_s;
  logic w_tick;
  logic w_done;
  logic w_par;

  assign w_rx = r_sync2;

`ifdef UART_RX_MAJORITY_EN
  logic r_h1;
  logic r_h2;

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      r_h1 <= 1'b1;
      r_h2 <= 1'b1;
    end else begin
      r_h1 <= w_rx;
      r_h2 <= r_h1;
    end
  end

  // decided one cycle after the nominal point, over point-1..point+1
  assign w_s = (r_h1 & r_h2) | (r_h1 & w_rx) | (r_h2 & w_rx);
`else
  assign w_s = w_rx;
`endif

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_serial_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_state == ST_START) ? (r_cnt == START_CMP)
                                        : (r_cnt == BIT_CMP);
  assign w_done = (r_state == ST_STOP) && w_tick && (r_idx == STOP_LAST);
  assign w_par  = (^r_shift) ^ w_s;

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pe    <= 1'b0;
      r_fe    <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
      r_ovr <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_cnt  <= '0;
          r_idx  <= '0;
          r_perr <= 1'b0;
          r_ferr <= 1'b0;
          if (!w_rx) r_state <= ST_START;
        end
        ST_START: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_state <= w_s ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_shift <= {w_s, r_shift[DATA_BITS-1:1]};
            if (r_idx == DATA_LAST) begin
              r_idx   <= '0;
              r_state <= (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_perr  <= (PARITY == 1) ? w_par : !w_par;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (!w_s) r_ferr <= 1'b1;
            if (r_idx == STOP_LAST) r_state <= ST_IDLE;
            else r_idx <= r_idx + IW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // a completing frame wins over the clear from a same-cycle accept
      if (w_done) begin
        if (!r_valid || rx_if.rx_ready_in) begin
          r_valid <= 1'b1;
          r_data  <= r_shift;
          r_pe    <= r_perr;
          r_fe    <= r_ferr | ~w_s;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && rx_if.rx_ready_in) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_if.rx_valid_out    = r_valid;
  assign rx_if.rx_data_out     = r_data;
  assign rx_if.parity_err_out  = r_pe;
  assign rx_if.frame_err_out   = r_fe;
  assign rx_if.overrun_err_out = r_ovr;
endmodule
